// File: rtl/a1_pkg.sv
// Shared constants for the scaler chain stages.
package a1_pkg;
  localparam logic SCALER_RESET_VAL = 1'b0;
endpackage

// File: rtl/scaler_stage.sv
// Registered divide-by-2 toggle stage with synchronous reset; reused by every scaler stage.
module scaler_stage
  import a1_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  output logic o_q,
  output logic o_q_n_prev
);

  // NOTE: declaration initialiser gives the power-on value without an initial block.
  logic r_q = SCALER_RESET_VAL;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_q <= SCALER_RESET_VAL;
    else       r_q <= ~r_q;
  end

  assign o_q        = r_q;
  assign o_q_n_prev = ~r_q;

endmodule

// File: rtl/a1.sv
// Scaler stage 2: divides FS01_ by two and derives the FS02A duplicate and F02A/F02B phase strobes.
module a1
  import a1_pkg::*;
(
  input  logic rst,
  input  logic FS01_,
  output logic F02A,
  output logic F02B,
  output logic FS02,
  output logic FS02A
);

  logic w_fs02;
  logic w_fs02_n;

  logic r_fs02a = SCALER_RESET_VAL;
  logic r_f02a  = SCALER_RESET_VAL;
  logic r_f02b  = SCALER_RESET_VAL;

  scaler_stage u_stage (
    .i_clk      (FS01_),
    .i_rst      (rst),
    .o_q        (w_fs02),
    .o_q_n_prev (w_fs02_n)
  );

  // NOTE: non-blocking assignments so every register sees the pre-edge fs02.
  always_ff @(posedge FS01_) begin
    if (rst) begin
      r_fs02a <= SCALER_RESET_VAL;
      r_f02a  <= SCALER_RESET_VAL;
      r_f02b  <= SCALER_RESET_VAL;
    end else begin
      r_fs02a <= w_fs02_n;
      r_f02a  <= w_fs02_n;
      r_f02b  <= w_fs02;
    end
  end

  assign FS02  = w_fs02;
  assign FS02A = r_fs02a;
  assign F02A  = r_f02a;
  assign F02B  = r_f02b;

endmodule

// File: tb/tb_a1.sv
// Directed self-checking bench for the a1 stage-2 scaler.
`timescale 1ns/1ps
module tb_a1;

  logic rst;
  logic clk;
  logic F02A, F02B, FS02, FS02A;

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  logic exp_fs02;
  int   rises;
  int   a_high;
  logic prev_fs02;

  a1 dut (
    .rst   (rst),
    .FS01_ (clk),
    .F02A  (F02A),
    .F02B  (F02B),
    .FS02  (FS02),
    .FS02A (FS02A)
  );

  initial begin
    clk = 1'b0;
    forever #4883 clk = ~clk;
  end

  task automatic check(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs == exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic e_fs02, input logic e_a,
                           input logic e_b);
    check({tag, "_fs02"},  FS02,  e_fs02);
    check({tag, "_fs02a"}, FS02A, e_fs02);
    check({tag, "_f02a"},  F02A,  e_a);
    check({tag, "_f02b"},  F02B,  e_b);
  endtask

  initial begin
    // Power-on with reset held but no clock edge: power-on zeros apply.
    rst = 1'b1;
    #2000;
    check_all("poweron", 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // First run edge at 4.883 us.
    @(negedge clk);
    check_all("first_edge", 1'b1, 1'b1, 1'b0);
    exp_fs02 = 1'b1;

    // Free run ~500 us: outputs alternate, strobes complementary.
    for (int i = 0; i < 51; i++) begin
      @(negedge clk);
      exp_fs02 = ~exp_fs02;
      check_all("run", exp_fs02, exp_fs02, ~exp_fs02);
      check("run_excl", F02A & F02B, 1'b0);
    end

    // Move to FS02=1 before asserting reset.
    if (exp_fs02 == 1'b0) begin
      @(negedge clk);
      exp_fs02 = 1'b1;
    end
    check("pre_reset_fs02", FS02, 1'b1);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_all("reset", 1'b0, 1'b0, 1'b0);
    end
    rst = 1'b0;
    @(negedge clk);
    check_all("release", 1'b1, 1'b1, 1'b0);
    exp_fs02 = 1'b1;

    // Reset pulse between rising edges never gets sampled.
    @(posedge clk);
    exp_fs02 = ~exp_fs02;
    #1000 rst = 1'b1;
    #1000 rst = 1'b0;
    @(negedge clk);
    check_all("glitch_a", exp_fs02, exp_fs02, ~exp_fs02);
    @(negedge clk);
    exp_fs02 = ~exp_fs02;
    check_all("glitch_b", exp_fs02, exp_fs02, ~exp_fs02);

    // Edge count over 100 rising edges after reset.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("cnt_start", FS02, 1'b0);
    prev_fs02 = FS02;
    rises  = 0;
    a_high = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (FS02 && !prev_fs02) rises++;
      if (F02A) a_high++;
      prev_fs02 = FS02;
    end
    check_int("cnt_rises", rises, 50);
    check_int("cnt_f02a_high", a_high, 50);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
